// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction field positions, default reset PC and the opcode/funct values
// the downstream controller decodes.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetchState_t;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction memory request/response bus. The fetch unit is the master;
// the memory is the slave.
interface inst_fetch_unit_if
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps one request outstanding to
// instruction memory, holds the fetched word for the decoder and handles PC
// redirects, discarding any in-flight response a redirect makes stale.
// Optional build macro FETCH_STATS_EN adds fetch_count / kill_count outputs.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                reset,
  inst_fetch_unit_if.master   imem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                inst_valid,
  output logic [INST_W-1:0]   inst,
  output logic [ADDR_W-1:0]   inst_pc,
  output logic [ADDR_W-1:0]   pc_plus4,
  output logic [5:0]          opcode,
  output logic [5:0]          funct
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         kill_count
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetchState_t       state;
  logic [ADDR_W-1:0] pc;
  logic              kill;
  logic [ADDR_W-1:0] redirectTarget;

  assign redirectTarget = redirect_pc & ALIGN_MASK;

  assign imem.imem_req  = (state == REQ) && !reset;
  assign imem.imem_addr = pc;

  assign pc_plus4 = inst_pc + ADDR_W'(4);
  assign opcode   = inst[OPCODE_MSB:OPCODE_LSB];
  assign funct    = inst[FUNCT_MSB:FUNCT_LSB];

  // Fetch FSM, PC register and instruction register.
  // pc keeps the outstanding request address until its response lands, so
  // inst_pc is taken from pc and pc only advances on a captured response.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC & ALIGN_MASK;
      state      <= REQ;
      kill       <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (redirect_valid) pc <= redirectTarget;
          if (imem.imem_ready) begin
            state <= WAIT;
            kill  <= redirect_valid;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            state <= REQ;
            kill  <= 1'b0;
            if (kill || redirect_valid) begin
              if (redirect_valid) pc <= redirectTarget;
            end else begin
              inst       <= imem.imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + ADDR_W'(4);
              state      <= HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= redirectTarget;
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || !stall) begin
            inst_valid <= 1'b0;
            state      <= REQ;
            if (redirect_valid) pc <= redirectTarget;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic dropResp;
  assign dropResp = (state == WAIT) && imem.imem_rvalid && (kill || redirect_valid);

  // Accepted-instruction and dropped-response counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      kill_count  <= '0;
    end else begin
      if (inst_valid && !stall) fetch_count <= fetch_count + 32'd1;
      if (dropResp)             kill_count  <= kill_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed memory/redirect stimulus on a main
// instance checked every cycle against a transaction-level model, plus a
// second instance with RESET_PC at the top of the address space running
// against an always-ready memory to cover PC wrap.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectPc;

  logic        instValid, instValid2;
  logic [31:0] inst, inst2, instPc, instPc2, pcPlus4, pcPlus42;
  logic [5:0]  opcode, opcode2, funct, funct2;
`ifdef FETCH_STATS_EN
  logic [31:0] fetchCount, killCount, fetchCount2, killCount2;
`endif

  int nChecks = 0;
  int nFails  = 0;

  inst_fetch_unit_if #(.ADDR_W(32)) bus ();
  inst_fetch_unit_if #(.ADDR_W(32)) bus2 ();

  inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem(bus.master), .stall(stall),
    .redirect_valid(redirectValid), .redirect_pc(redirectPc),
    .inst_valid(instValid), .inst(inst), .inst_pc(instPc), .pc_plus4(pcPlus4),
    .opcode(opcode), .funct(funct)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetchCount), .kill_count(killCount)
`endif
  );

  inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .imem(bus2.master), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(instValid2), .inst(inst2), .inst_pc(instPc2), .pc_plus4(pcPlus42),
    .opcode(opcode2), .funct(funct2)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetchCount2), .kill_count(killCount2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Always-ready memory for the wrap instance: data = ~address, one cycle later.
  initial bus2.imem_ready = 1'b1;
  always @(posedge clk) begin
    bus2.imem_rvalid <= bus2.imem_req & bus2.imem_ready;
    bus2.imem_rdata  <= ~bus2.imem_addr;
  end

  // Transaction model: a fetch is either requesting, outstanding (possibly
  // stale) or held for the consumer.
  logic        modelLive = 1'b0;
  logic        mHeld, mOutstanding, mStale;
  logic [31:0] mPc, mInst, mInstPc, mFetched, mKilled;

  always @(posedge clk) begin
    if (reset) begin
      modelLive    <= 1'b1;
      mPc          <= 32'h0;
      mHeld        <= 1'b0;
      mOutstanding <= 1'b0;
      mStale       <= 1'b0;
      mInst        <= 32'h0;
      mInstPc      <= 32'h0;
      mFetched     <= 32'h0;
      mKilled      <= 32'h0;
    end else if (mHeld) begin
      if (!stall) mFetched <= mFetched + 32'd1;
      if (!stall || redirectValid) mHeld <= 1'b0;
      if (redirectValid) mPc <= redirectPc & ~32'h3;
    end else if (mOutstanding) begin
      if (bus.imem_rvalid) begin
        mOutstanding <= 1'b0;
        if (mStale || redirectValid) begin
          mStale  <= 1'b0;
          mKilled <= mKilled + 32'd1;
          if (redirectValid) mPc <= redirectPc & ~32'h3;
        end else begin
          mHeld   <= 1'b1;
          mInst   <= bus.imem_rdata;
          mInstPc <= mPc;
          mPc     <= mPc + 32'd4;
        end
      end else if (redirectValid) begin
        mPc    <= redirectPc & ~32'h3;
        mStale <= 1'b1;
      end
    end else begin
      if (redirectValid) mPc <= redirectPc & ~32'h3;
      if (bus.imem_ready) begin
        mOutstanding <= 1'b1;
        mStale       <= redirectValid;
      end
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (modelLive) begin
      logic expReq;
      expReq = !reset && !mHeld && !mOutstanding;
      chk("m_req", 32'(bus.imem_req), 32'(expReq));
      if (expReq) chk("m_addr", bus.imem_addr, mPc);
      chk("m_inst_valid", 32'(instValid), 32'(mHeld));
      chk("m_inst", inst, mInst);
      chk("m_inst_pc", instPc, mInstPc);
      chk("m_pc_plus4", pcPlus4, mInstPc + 32'd4);
      chk("m_opcode", 32'(opcode), mInst >> 26);
      chk("m_funct", 32'(funct), mInst & 32'h3F);
`ifdef FETCH_STATS_EN
      chk("m_fetch_count", fetchCount, mFetched);
      chk("m_kill_count", killCount, mKilled);
`endif
    end
  end

  // Wrap instance: RESET_PC = 0xFFFF_FFFC.
  initial begin
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (reset !== 1'b0 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    chk("wrap_reset_release", 32'(waitCnt < 50), 32'd1);
    chk("wrap_req0", 32'(bus2.imem_req), 32'd1);
    chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_wait_req", 32'(bus2.imem_req), 32'd0);
    @(negedge clk);
    chk("wrap_valid", 32'(instValid2), 32'd1);
    chk("wrap_inst_pc", instPc2, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pcPlus42, 32'h0000_0000);
    chk("wrap_inst", inst2, 32'h0000_0003);
    @(negedge clk);
    chk("wrap_next_req", 32'(bus2.imem_req), 32'd1);
    chk("wrap_next_addr", bus2.imem_addr, 32'h0000_0000);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with literal expectations.
  initial begin
    reset = 1'b1; stall = 1'b0; redirectValid = 1'b0; redirectPc = 32'h0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    tick(); tick();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(instValid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", instPc, 32'h0);

    // First fetch: ADDI at 0x0, ready=1, rvalid one cycle after acceptance.
    reset = 1'b0; bus.imem_ready = 1'b1;
    #1;
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    tick();
    chk("first_wait_req", 32'(bus.imem_req), 32'd0);
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2008_0005;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("first_valid", 32'(instValid), 32'd1);
    chk("first_opcode", 32'(opcode), 32'(OP_ADDI));
    chk("first_funct", 32'(funct), 32'h5);
    chk("first_inst_pc", instPc, 32'h0);
    chk("first_pc_plus4", pcPlus4, 32'h4);
    tick();
    chk("accept_valid", 32'(instValid), 32'd0);
    chk("second_req", 32'(bus.imem_req), 32'd1);
    chk("second_addr", bus.imem_addr, 32'h4);

    // Stall for 5 cycles while holding an ADD.
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0020; stall = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(instValid), 32'd1);
      chk("stall_inst", inst, 32'h0000_0020);
      chk("stall_funct", 32'(funct), 32'(FUNCT_ADD));
      chk("stall_req", 32'(bus.imem_req), 32'd0);
      tick();
    end
    chk("stall_end_valid", 32'(instValid), 32'd1);
    stall = 1'b0;
    tick();
    chk("post_stall_req", 32'(bus.imem_req), 32'd1);
    chk("post_stall_addr", bus.imem_addr, 32'h8);

    // Redirect during WAIT; late response is dropped.
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0; redirectValid = 1'b1; redirectPc = 32'h0000_0100;
    tick();
    redirectValid = 1'b0;
    chk("kill_wait_req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("drop_valid", 32'(instValid), 32'd0);
    chk("drop_inst", inst, 32'h0000_0020);
    chk("drop_req", 32'(bus.imem_req), 32'd1);
    chk("drop_addr", bus.imem_addr, 32'h100);
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0820;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("redir_fetch_pc", instPc, 32'h100);
    chk("redir_fetch_plus4", pcPlus4, 32'h104);

    // Redirect in HOLD overrides stall; target bits [1:0] are cleared.
    stall = 1'b1; redirectValid = 1'b1; redirectPc = 32'h0000_0203;
    tick();
    stall = 1'b0; redirectValid = 1'b0;
    chk("hold_redir_valid", 32'(instValid), 32'd0);
    chk("hold_redir_addr", bus.imem_addr, 32'h200);

    // Redirect in REQ while accepted: response is stale.
    bus.imem_ready = 1'b1; redirectValid = 1'b1; redirectPc = 32'h0000_0300;
    tick();
    bus.imem_ready = 1'b0; redirectValid = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_1111;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("req_kill_valid", 32'(instValid), 32'd0);
    chk("req_kill_addr", bus.imem_addr, 32'h300);

    // Redirect in REQ while not accepted.
    redirectValid = 1'b1; redirectPc = 32'h0000_0400;
    tick();
    redirectValid = 1'b0;
    chk("req_redir_addr", bus.imem_addr, 32'h400);

    // Redirect coinciding with the response.
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2222_2222;
    redirectValid = 1'b1; redirectPc = 32'h0000_0500;
    tick();
    bus.imem_rvalid = 1'b0; redirectValid = 1'b0;
    chk("coinc_valid", 32'(instValid), 32'd0);
    chk("coinc_addr", bus.imem_addr, 32'h500);
`ifdef FETCH_STATS_EN
    chk("stats_fetch", fetchCount, 32'd2);
    chk("stats_kill", killCount, 32'd3);
`endif

    // Normal fetch resumes at the redirect target.
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0C00_0040;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("jal_inst_pc", instPc, 32'h500);
    chk("jal_opcode", 32'(opcode), 32'(OP_JAL));
    tick();
    chk("jal_next_addr", bus.imem_addr, 32'h504);

    // Reset in WAIT, then a late response that must be ignored.
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0; reset = 1'b1;
    tick();
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_valid", 32'(instValid), 32'd0);
    chk("mid_rst_inst", inst, 32'h0);
`ifdef FETCH_STATS_EN
    chk("mid_rst_fetch", fetchCount, 32'd0);
    chk("mid_rst_kill", killCount, 32'd0);
`endif
    reset = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h3333_3333;
    #1;
    chk("post_rst_req", 32'(bus.imem_req), 32'd1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    tick();
    bus.imem_rvalid = 1'b0;
    chk("late_valid", 32'(instValid), 32'd0);
    chk("late_addr", bus.imem_addr, 32'h0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
